fetch_branch_ctrl: RTL and testbench
====================================

FETCH_BRANCH_CTRL -- requirements
Module: fetch_branch_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Run, input, 1, start request while in HALTED.
REQ-004 SHALL have port Continue, input, 1, resume request while in PAUSE.
REQ-005 SHALL have port IR, input, 16, current instruction register contents; opcode = IR[15:12].
REQ-006 SHALL have port BEN, input, 1, registered branch-enable from the condition-code stage.
REQ-007 SHALL have port Mem_ready, input, 1, memory read data valid.
REQ-008 SHALL have port Exec_done, input, 1, execute unit finished the current instruction.
REQ-009 SHALL have outputs LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_PC, GatePC, GateMDR, Mem_OE, Exec_req, all 1 bit, active-high.
REQ-010 SHALL have output PCMUX, 2 bits: 00 = PC+1, 01 = PC+SEXT(IR[8:0]); 10 and 11 are never driven.
REQ-011 SHALL have output State_dbg, 4 bits, current state encoding for debug.

Function
REQ-012 SHALL be a Moore FSM; every output SHALL be a function of the current state only.
REQ-013 SHALL have states HALTED, S18, S33, S35, S32, S00, S22, EXEC, PAUSE.
REQ-014 HALTED: all outputs 0; go to S18 when Run=1, else stay.
REQ-015 S18: GatePC=1, LD_MAR=1, LD_PC=1, PCMUX=00; go to S33 unconditionally.
REQ-016 S33: Mem_OE=1, LD_MDR=1; stay while Mem_ready=0; go to S35 on the cycle Mem_ready=1, with no cycle limit.
REQ-017 S35: GateMDR=1, LD_IR=1; go to S32.
REQ-018 S32: LD_BEN=1. Next state: opcode 0000 -> S00; 1101 -> PAUSE; else -> EXEC.
REQ-019 S00: no outputs asserted; BEN=1 -> S22; BEN=0 -> S18. BEN is sampled exactly one cycle after LD_BEN.
REQ-020 S22: LD_PC=1, PCMUX=01; go to S18.
REQ-021 EXEC: Exec_req=1; stay until Exec_done=1, then go to S18. Exec_done=1 on the first EXEC cycle SHALL be accepted, giving a one-cycle EXEC.
REQ-022 Exec_done outside EXEC SHALL be ignored.
REQ-023 PAUSE: all outputs 0; Continue=1 -> S18, else stay.
REQ-024 Run and Continue SHALL be ignored outside HALTED and PAUSE respectively.
REQ-025 No two of GatePC, GateMDR SHALL be asserted in the same state.
REQ-026 Fetch-to-decode latency with Mem_ready held high SHALL be 4 cycles (S18, S33, S35, S32).
REQ-027 BR taken SHALL cost 6 cycles (S18 to S22); BR not taken SHALL cost 5 cycles.

Reset
REQ-028 Reset=1 SHALL force HALTED immediately, without waiting for Clk, from any state including S33 mid-read and EXEC.
REQ-029 During and after reset, all outputs SHALL be 0 and PCMUX SHALL be 00.
REQ-030 After Reset deasserts, the FSM SHALL remain in HALTED until Run=1 is sampled on a rising edge.

Verification
REQ-031 Reset, Run=1, Mem_ready=1, IR=0x0E05, BEN=1 -> states S18,S33,S35,S32,S00,S22,S18; LD_BEN high only in S32; PCMUX=01 with LD_PC in S22.
REQ-032 Same sequence with IR=0x0005 (nzp=000) and BEN=0 -> S00 then S18; S22 never entered; LD_PC asserted only in S18.
REQ-033 Mem_ready held 0 for 3 cycles in S33 -> S33 held for 4 cycles with Mem_OE=1 and LD_MDR=1 throughout; S35 follows.
REQ-034 IR=0x1240 (ADD): Exec_req=1 for 3 cycles, then Exec_done=1 -> S18 next cycle. Repeat with Exec_done already 1 on entry -> EXEC lasts exactly 1 cycle.
REQ-035 IR=0xD000 -> PAUSE; Run pulses ignored; Continue=1 -> S18.
REQ-036 Reset asserted asynchronously, between edges, while in S33 and again while in EXEC -> outputs 0 and State_dbg=HALTED before the next edge.

Source files
------------

// File: rtl/fetch_branch_ctrl.sv
// Fetch/decode/branch sequencer for a small LC-3 style datapath.
// Moore FSM; State_dbg encodings: HALTED=0 S18=1 S33=2 S35=3 S32=4 S00=5 S22=6 EXEC=7 PAUSE=8.
module fetch_branch_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  input  logic        Mem_ready,
  input  logic        Exec_done,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_PC,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        Mem_OE,
  output logic        Exec_req,
  output logic [1:0]  PCMUX,
  output logic [3:0]  State_dbg
);

  typedef enum logic [3:0] {
    StHalted = 4'd0,
    St18     = 4'd1,
    St33     = 4'd2,
    St35     = 4'd3,
    St32     = 4'd4,
    St00     = 4'd5,
    St22     = 4'd6,
    StExec   = 4'd7,
    StPause  = 4'd8
  } state_e;

  localparam logic [3:0] OpBr    = 4'b0000;
  localparam logic [3:0] OpPause = 4'b1101;

  state_e     state_q, state_d;
  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[15:12];
  // Only the opcode field steers the sequencer; the rest of IR belongs to the datapath.
  assign unused_ir = ^IR[11:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StHalted;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalted: if (Run)       state_d = St18;
      St18:                    state_d = St33;
      St33:     if (Mem_ready) state_d = St35;
      St35:                    state_d = St32;
      St32: begin
        if (opcode == OpBr) begin
          state_d = St00;
        end else if (opcode == OpPause) begin
          state_d = StPause;
        end else begin
          state_d = StExec;
        end
      end
      // BEN was loaded in S32, so it is valid here one cycle later.
      St00:     state_d = BEN ? St22 : St18;
      St22:                    state_d = St18;
      StExec:   if (Exec_done) state_d = St18;
      StPause:  if (Continue)  state_d = St18;
      default:                 state_d = StHalted;
    endcase
  end

  always_comb begin
    LD_MAR   = 1'b0;
    LD_MDR   = 1'b0;
    LD_IR    = 1'b0;
    LD_BEN   = 1'b0;
    LD_PC    = 1'b0;
    GatePC   = 1'b0;
    GateMDR  = 1'b0;
    Mem_OE   = 1'b0;
    Exec_req = 1'b0;
    PCMUX    = 2'b00;
    unique case (state_q)
      St18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      St33: begin
        Mem_OE = 1'b1;
        LD_MDR = 1'b1;
      end
      St35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      St32:   LD_BEN = 1'b1;
      St22: begin
        LD_PC = 1'b1;
        PCMUX = 2'b01;
      end
      StExec: Exec_req = 1'b1;
      default: ;
    endcase
  end

  assign State_dbg = state_q;

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// Scoreboarded bench for fetch_branch_ctrl: expected outputs are queued as each
// cycle's stimulus is driven and compared one clock edge later.
module tb_fetch_branch_ctrl;

  localparam logic [3:0] S_HALT  = 4'd0;
  localparam logic [3:0] S18     = 4'd1;
  localparam logic [3:0] S33     = 4'd2;
  localparam logic [3:0] S35     = 4'd3;
  localparam logic [3:0] S32     = 4'd4;
  localparam logic [3:0] S00     = 4'd5;
  localparam logic [3:0] S22     = 4'd6;
  localparam logic [3:0] S_EXEC  = 4'd7;
  localparam logic [3:0] S_PAUSE = 4'd8;

  logic        Clk = 1'b0;
  logic        Reset, Run, Continue, BEN, Mem_ready, Exec_done;
  logic [15:0] IR;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_PC, GatePC, GateMDR, Mem_OE, Exec_req;
  logic [1:0]  PCMUX;
  logic [3:0]  State_dbg;

  fetch_branch_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .Continue  (Continue),
    .IR        (IR),
    .BEN       (BEN),
    .Mem_ready (Mem_ready),
    .Exec_done (Exec_done),
    .LD_MAR    (LD_MAR),
    .LD_MDR    (LD_MDR),
    .LD_IR     (LD_IR),
    .LD_BEN    (LD_BEN),
    .LD_PC     (LD_PC),
    .GatePC    (GatePC),
    .GateMDR   (GateMDR),
    .Mem_OE    (Mem_OE),
    .Exec_req  (Exec_req),
    .PCMUX     (PCMUX),
    .State_dbg (State_dbg)
  );

  always #5 Clk = ~Clk;

  wire [14:0] obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_PC, GatePC, GateMDR, Mem_OE, Exec_req,
                     PCMUX, State_dbg};

  typedef struct {
    logic        run, cont, ben, mr, ed;
    logic [15:0] ir;
    logic [3:0]  st;
  } vec_t;

  vec_t        stim[$];
  logic [14:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Reference output table, one row per state.
  function automatic logic [14:0] model_outs(input logic [3:0] st);
    logic mar, mdr, ldir, ldben, ldpc, gpc, gmdr, oe, xr;
    logic [1:0] mux;
    {mar, mdr, ldir, ldben, ldpc, gpc, gmdr, oe, xr} = 9'b0;
    mux = 2'b00;
    case (st)
      S18:     begin gpc = 1'b1; mar = 1'b1; ldpc = 1'b1; end
      S33:     begin oe = 1'b1; mdr = 1'b1; end
      S35:     begin gmdr = 1'b1; ldir = 1'b1; end
      S32:     ldben = 1'b1;
      S22:     begin ldpc = 1'b1; mux = 2'b01; end
      S_EXEC:  xr = 1'b1;
      default: ;
    endcase
    return {mar, mdr, ldir, ldben, ldpc, gpc, gmdr, oe, xr, mux, st};
  endfunction

  task automatic add(input logic run, input logic cont, input logic ben, input logic mr,
                     input logic ed, input logic [15:0] ir, input logic [3:0] st);
    vec_t v;
    v.run = run; v.cont = cont; v.ben = ben; v.mr = mr; v.ed = ed; v.ir = ir; v.st = st;
    stim.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    Run = v.run; Continue = v.cont; BEN = v.ben; Mem_ready = v.mr; Exec_done = v.ed; IR = v.ir;
    sb.push_back(model_outs(v.st));
  endtask

  task automatic do_reset();
    Run = 0; Continue = 0; BEN = 0; Mem_ready = 0; Exec_done = 0; IR = 16'h0000;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    vec_t v;
    int k = 0;
    Reset = 1'b1; Run = 1'b1; Continue = 1'b1; Mem_ready = 1'b1; Exec_done = 1'b1;
    BEN = 1'b1; IR = 16'h1240;
    #2;
    sb.push_back(model_outs(S_HALT));
    exp = sb.pop_front(); n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_async got %h expected %h", obs, exp);
    end
    // Run held high through an edge while Reset is asserted must not start fetch.
    @(posedge Clk); #1;
    sb.push_back(model_outs(S_HALT));
    exp = sb.pop_front(); n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_hold got %h expected %h", obs, exp);
    end
    Reset = 1'b0;
    add(0, 1, 0, 1, 1, 16'h1240, S_HALT);
    add(0, 0, 0, 1, 1, 16'h1240, S_HALT);
    add(1, 0, 0, 1, 0, 16'h1240, S18);
    while (stim.size() > 0) begin
      v = stim.pop_front(); drive(v);
      @(posedge Clk); #1;
      exp = sb.pop_front(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL reset_release step %0d got %h expected %h", k, obs, exp);
      end
      k++;
    end
  endtask

  task automatic test_branch_taken();
    logic [14:0] exp;
    vec_t v;
    int k = 0;
    do_reset();
    add(1, 0, 1, 1, 0, 16'h0E05, S18);
    add(1, 0, 1, 1, 0, 16'h0E05, S33);
    add(1, 0, 1, 1, 0, 16'h0E05, S35);
    add(1, 0, 1, 1, 0, 16'h0E05, S32);
    add(1, 0, 1, 1, 0, 16'h0E05, S00);
    add(1, 0, 1, 1, 0, 16'h0E05, S22);
    add(1, 0, 1, 1, 0, 16'h0E05, S18);
    while (stim.size() > 0) begin
      v = stim.pop_front(); drive(v);
      @(posedge Clk); #1;
      exp = sb.pop_front(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL br_taken step %0d got %h expected %h", k, obs, exp);
      end
      k++;
    end
  endtask

  task automatic test_branch_not_taken();
    logic [14:0] exp;
    vec_t v;
    int k = 0;
    do_reset();
    add(1, 0, 0, 1, 0, 16'h0005, S18);
    add(0, 0, 0, 1, 0, 16'h0005, S33);
    add(0, 0, 0, 1, 0, 16'h0005, S35);
    add(0, 0, 0, 1, 0, 16'h0005, S32);
    add(0, 0, 0, 1, 0, 16'h0005, S00);
    add(0, 0, 0, 1, 0, 16'h0005, S18);
    add(0, 0, 0, 1, 0, 16'h0005, S33);
    while (stim.size() > 0) begin
      v = stim.pop_front(); drive(v);
      @(posedge Clk); #1;
      exp = sb.pop_front(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL br_not_taken step %0d got %h expected %h", k, obs, exp);
      end
      k++;
    end
  endtask

  task automatic test_mem_wait();
    logic [14:0] exp;
    vec_t v;
    int k = 0;
    do_reset();
    add(1, 0, 0, 0, 0, 16'h1240, S18);
    add(0, 0, 0, 0, 0, 16'h1240, S33);
    add(0, 1, 0, 0, 1, 16'h1240, S33);
    add(1, 0, 0, 0, 1, 16'h1240, S33);
    add(0, 0, 0, 0, 0, 16'h1240, S33);
    add(0, 0, 0, 1, 0, 16'h1240, S35);
    add(0, 0, 0, 1, 0, 16'h1240, S32);
    while (stim.size() > 0) begin
      v = stim.pop_front(); drive(v);
      @(posedge Clk); #1;
      exp = sb.pop_front(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL mem_wait step %0d got %h expected %h", k, obs, exp);
      end
      k++;
    end
  endtask

  task automatic test_exec();
    logic [14:0] exp;
    vec_t v;
    int k = 0;
    do_reset();
    add(1, 0, 0, 1, 0, 16'h1240, S18);
    add(0, 0, 0, 1, 0, 16'h1240, S33);
    add(0, 0, 0, 1, 0, 16'h1240, S35);
    add(0, 0, 0, 1, 0, 16'h1240, S32);
    add(0, 0, 0, 1, 0, 16'h1240, S_EXEC);
    add(0, 0, 0, 1, 0, 16'h1240, S_EXEC);
    add(0, 0, 0, 1, 0, 16'h1240, S_EXEC);
    add(0, 0, 0, 1, 1, 16'h1240, S18);
    // Exec_done already high on entry: a single EXEC cycle.
    add(0, 0, 0, 1, 1, 16'h1240, S33);
    add(0, 0, 0, 1, 1, 16'h1240, S35);
    add(0, 0, 0, 1, 1, 16'h1240, S32);
    add(0, 0, 0, 1, 1, 16'h1240, S_EXEC);
    add(0, 0, 0, 1, 1, 16'h1240, S18);
    while (stim.size() > 0) begin
      v = stim.pop_front(); drive(v);
      @(posedge Clk); #1;
      exp = sb.pop_front(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL exec step %0d got %h expected %h", k, obs, exp);
      end
      k++;
    end
  endtask

  task automatic test_pause();
    logic [14:0] exp;
    vec_t v;
    int k = 0;
    do_reset();
    add(0, 1, 0, 1, 0, 16'hD000, S_HALT);
    add(1, 0, 0, 1, 0, 16'hD000, S18);
    add(0, 0, 0, 1, 0, 16'hD000, S33);
    add(0, 0, 0, 1, 0, 16'hD000, S35);
    add(0, 0, 0, 1, 0, 16'hD000, S32);
    add(0, 0, 0, 1, 0, 16'hD000, S_PAUSE);
    add(1, 0, 0, 1, 1, 16'hD000, S_PAUSE);
    add(0, 0, 0, 1, 0, 16'hD000, S_PAUSE);
    add(1, 0, 0, 1, 0, 16'hD000, S_PAUSE);
    add(0, 1, 0, 1, 0, 16'hD000, S18);
    add(0, 0, 0, 1, 0, 16'hD000, S33);
    while (stim.size() > 0) begin
      v = stim.pop_front(); drive(v);
      @(posedge Clk); #1;
      exp = sb.pop_front(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL pause step %0d got %h expected %h", k, obs, exp);
      end
      k++;
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] exp;
    vec_t v;
    int k = 0;
    do_reset();
    add(1, 0, 0, 0, 0, 16'h1240, S18);
    add(0, 0, 0, 0, 0, 16'h1240, S33);
    add(0, 0, 0, 0, 0, 16'h1240, S33);
    while (stim.size() > 0) begin
      v = stim.pop_front(); drive(v);
      @(posedge Clk); #1;
      exp = sb.pop_front(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL async_pre_s33 step %0d got %h expected %h", k, obs, exp);
      end
      k++;
    end
    #3 Reset = 1'b1;
    #1;
    sb.push_back(model_outs(S_HALT));
    exp = sb.pop_front(); n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL async_in_s33 got %h expected %h", obs, exp);
    end
    #1 Reset = 1'b0;
    add(0, 0, 0, 1, 0, 16'h1240, S_HALT);
    add(1, 0, 0, 1, 0, 16'h1240, S18);
    add(0, 0, 0, 1, 0, 16'h1240, S33);
    add(0, 0, 0, 1, 0, 16'h1240, S35);
    add(0, 0, 0, 1, 0, 16'h1240, S32);
    add(0, 0, 0, 1, 0, 16'h1240, S_EXEC);
    add(0, 0, 0, 1, 0, 16'h1240, S_EXEC);
    k = 0;
    while (stim.size() > 0) begin
      v = stim.pop_front(); drive(v);
      @(posedge Clk); #1;
      exp = sb.pop_front(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL async_pre_exec step %0d got %h expected %h", k, obs, exp);
      end
      k++;
    end
    #3 Reset = 1'b1;
    #1;
    sb.push_back(model_outs(S_HALT));
    exp = sb.pop_front(); n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL async_in_exec got %h expected %h", obs, exp);
    end
    #1 Reset = 1'b0;
    Run = 1'b0; Exec_done = 1'b1;
    sb.push_back(model_outs(S_HALT));
    @(posedge Clk); #1;
    exp = sb.pop_front(); n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL async_post_exec_idle got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t, expected $finish earlier", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_branch_taken();
    test_branch_not_taken();
    test_mem_wait();
    test_exec();
    test_pause();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
